// File: rtl/pc_unit_pkg.sv
// Shared definitions for the PC datapath and the control unit: next-PC select
// encodings, branch opcodes and default reset/exception addresses.
package pc_unit_pkg;

    typedef enum logic [2:0] {
        PCSRC_ALU_RESULT = 3'd0,
        PCSRC_ALU_OUT    = 3'd1,
        PCSRC_REG_A      = 3'd2,
        PCSRC_JUMP       = 3'd3
    } pcsrc_e;

    localparam logic [3:0]  OP_BEQ             = 4'd1;
    localparam logic [3:0]  OP_BNE             = 4'd2;
    localparam logic [15:0] RESET_PC_DEFAULT   = 16'h0000;
    localparam logic [15:0] EXC_VECTOR_DEFAULT = 16'h0FF0;

    // Jumps stay inside the current 8 KiB region selected by PC[15:13].
    function automatic logic [15:0] jump_target(input logic [15:0] pc,
                                                input logic [11:0] imm);
        return {pc[15:13], imm, 1'b0};
    endfunction

endpackage

// File: rtl/pc_unit_branch_cond.sv
// Branch condition evaluator: beq takes on Zero, bne takes on !Zero, every
// other opcode is not-taken.
module branch_cond
    import pc_unit_pkg::*;
(
    input  logic [3:0] Opcode,
    input  logic       Zero,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        if (Opcode == OP_BEQ) begin
            taken = Zero;
        end else if (Opcode == OP_BNE) begin
            taken = !Zero;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with branch/jump selection, exception entry (EPC/Cause),
// alignment fault tracking, a taken-branch pulse and a fetch counter.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [15:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWrite,
    input  logic        isBranch,
    input  logic [2:0]  PCSrc,
    input  logic [3:0]  Opcode,
    input  logic        Zero,
    input  logic [15:0] ALUResult,
    input  logic [15:0] ALUOut,
    input  logic [15:0] RegA,
    input  logic [11:0] JumpImm,
    input  logic        EPCWrite,
    input  logic        CauseWrite,
    input  logic        IntCause,
    output logic [15:0] PC,
    output logic [15:0] EPC,
    output logic [1:0]  Cause,
    output logic        BranchTaken,
    output logic [15:0] FetchCount
);

    logic [15:0] pc_q, pc_d;
    logic [15:0] epc_q, epc_d;
    logic        align_q, align_d;
    logic        int_cause_q, int_cause_d;
    logic        branch_taken_q, branch_taken_d;
    logic [15:0] fetch_count_q, fetch_count_d;

    logic        taken;
    logic [15:0] src_sel;
    logic        src_valid;
    logic        load_ok;

    branch_cond u_branch_cond (
        .Opcode (Opcode),
        .Zero   (Zero),
        .taken  (taken)
    );

    always_comb begin
        src_sel   = 16'h0000;
        src_valid = 1'b1;
        case (PCSrc)
            PCSRC_ALU_RESULT: src_sel = ALUResult;
            PCSRC_ALU_OUT:    src_sel = ALUOut;
            PCSRC_REG_A:      src_sel = RegA;
            PCSRC_JUMP:       src_sel = jump_target(pc_q, JumpImm);
            default:          src_valid = 1'b0;
        endcase
    end

    // Exception entry pre-empts any PC load requested in the same cycle.
    assign load_ok = !EPCWrite && src_valid && (PCWrite || (isBranch && taken));

    always_comb begin
        pc_d           = pc_q;
        epc_d          = epc_q;
        int_cause_d    = int_cause_q;
        align_d        = align_q;
        fetch_count_d  = fetch_count_q;
        branch_taken_d = load_ok && !PCWrite;

        if (EPCWrite) begin
            epc_d = pc_q - 16'd2;
            pc_d  = EXC_VECTOR;
        end else if (load_ok) begin
            pc_d = {src_sel[15:1], 1'b0};
        end

        if (CauseWrite) begin
            int_cause_d = IntCause;
            align_d     = 1'b0;
        end
        // A misaligned load in the same cycle wins over the CauseWrite clear.
        if (load_ok && src_sel[0]) begin
            align_d = 1'b1;
        end

        if (load_ok && PCSrc == PCSRC_ALU_RESULT) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc_q           <= RESET_PC;
            epc_q          <= 16'h0000;
            align_q        <= 1'b0;
            int_cause_q    <= 1'b0;
            branch_taken_q <= 1'b0;
            fetch_count_q  <= 16'h0000;
        end else begin
            pc_q           <= pc_d;
            epc_q          <= epc_d;
            align_q        <= align_d;
            int_cause_q    <= int_cause_d;
            branch_taken_q <= branch_taken_d;
            fetch_count_q  <= fetch_count_d;
        end
    end

    assign PC          = pc_q;
    assign EPC         = epc_q;
    assign Cause       = {align_q, int_cause_q};
    assign BranchTaken = branch_taken_q;
    assign FetchCount  = fetch_count_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit: branches, jumps, alignment faults,
// exception entry, fetch counter wrap and asynchronous reset.
module tb_pc_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        PCWrite, isBranch, Zero, EPCWrite, CauseWrite, IntCause;
    logic [2:0]  PCSrc;
    logic [3:0]  Opcode;
    logic [15:0] ALUResult, ALUOut, RegA;
    logic [11:0] JumpImm;
    logic [15:0] PC, EPC, FetchCount;
    logic [1:0]  Cause;
    logic        BranchTaken;

    int checks = 0;
    int failures = 0;

    pc_unit dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .PCWrite     (PCWrite),
        .isBranch    (isBranch),
        .PCSrc       (PCSrc),
        .Opcode      (Opcode),
        .Zero        (Zero),
        .ALUResult   (ALUResult),
        .ALUOut      (ALUOut),
        .RegA        (RegA),
        .JumpImm     (JumpImm),
        .EPCWrite    (EPCWrite),
        .CauseWrite  (CauseWrite),
        .IntCause    (IntCause),
        .PC          (PC),
        .EPC         (EPC),
        .Cause       (Cause),
        .BranchTaken (BranchTaken),
        .FetchCount  (FetchCount)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        PCWrite = 0; isBranch = 0; EPCWrite = 0; CauseWrite = 0; IntCause = 0;
        PCSrc = 3'd0; Opcode = 4'd0; Zero = 0;
    endtask

    // One clock edge, then sample 1 time unit later; controls return to idle.
    task automatic tick(input string name);
        @(posedge CLK);
        #1;
        $display("txn %-12s PC=%h EPC=%h Cause=%b BT=%b FC=%h",
                 name, PC, EPC, Cause, BranchTaken, FetchCount);
        idle();
    endtask

    initial begin
        Reset = 1'b1;
        ALUResult = 16'h0; ALUOut = 16'h0; RegA = 16'h0; JumpImm = 12'h0;
        idle();
        #2;
        check("rst_pc", PC, 16'h0000);
        check("rst_epc", EPC, 16'h0000);
        check("rst_cause", {14'd0, Cause}, 16'h0000);
        check("rst_bt", {15'd0, BranchTaken}, 16'h0000);
        check("rst_fc", FetchCount, 16'h0000);
        @(negedge CLK);
        Reset = 1'b0;

        PCWrite = 1; PCSrc = 3'd0; ALUResult = 16'h0002;
        tick("fetch");
        check("fetch_pc", PC, 16'h0002);
        check("fetch_fc", FetchCount, 16'h0001);

        isBranch = 1; PCSrc = 3'd1; Opcode = 4'd1; Zero = 1; ALUOut = 16'h0040;
        tick("beq_taken");
        check("beq_pc", PC, 16'h0040);
        check("beq_bt", {15'd0, BranchTaken}, 16'h0001);
        check("beq_fc", FetchCount, 16'h0001);
        tick("idle");
        check("bt_pulse_end", {15'd0, BranchTaken}, 16'h0000);

        isBranch = 1; PCSrc = 3'd1; Opcode = 4'd2; Zero = 1; ALUOut = 16'h0080;
        tick("bne_not");
        check("bne_not_pc", PC, 16'h0040);
        check("bne_not_bt", {15'd0, BranchTaken}, 16'h0000);

        isBranch = 1; PCSrc = 3'd1; Opcode = 4'd3; Zero = 0; ALUOut = 16'h0080;
        tick("op3_branch");
        check("op3_pc", PC, 16'h0040);

        isBranch = 1; PCSrc = 3'd1; Opcode = 4'd2; Zero = 0; ALUOut = 16'h0080;
        tick("bne_taken");
        check("bne_pc", PC, 16'h0080);
        check("bne_bt", {15'd0, BranchTaken}, 16'h0001);

        PCWrite = 1; PCSrc = 3'd1; ALUOut = 16'hA000;
        tick("load_a000");
        check("a000_pc", PC, 16'hA000);
        check("a000_bt", {15'd0, BranchTaken}, 16'h0000);
        PCWrite = 1; PCSrc = 3'd3; JumpImm = 12'h123;
        tick("jump");
        check("jump_pc", PC, 16'hA246);

        PCWrite = 1; PCSrc = 3'd2; RegA = 16'h1235;
        tick("jr_misalign");
        check("jr_pc", PC, 16'h1234);
        check("jr_cause", {14'd0, Cause}, 16'h0002);
        tick("idle");
        check("align_sticky", {14'd0, Cause}, 16'h0002);
        CauseWrite = 1; IntCause = 1;
        tick("cause_wr");
        check("cause_clear", {14'd0, Cause}, 16'h0001);

        PCWrite = 1; PCSrc = 3'd1; ALUOut = 16'h0011; CauseWrite = 1; IntCause = 0;
        tick("cause_vs_mis");
        check("cvm_pc", PC, 16'h0010);
        check("cvm_cause", {14'd0, Cause}, 16'h0002);

        PCWrite = 1; PCSrc = 3'd5; ALUResult = 16'h0300;
        tick("bad_pcsrc");
        check("bad_src_pc", PC, 16'h0010);
        check("bad_src_fc", FetchCount, 16'h0001);

        EPCWrite = 1; PCWrite = 1; PCSrc = 3'd0; ALUResult = 16'h0055;
        tick("exception");
        check("exc_epc", EPC, 16'h000E);
        check("exc_pc", PC, 16'h0FF0);
        check("exc_fc", FetchCount, 16'h0001);
        check("exc_cause", {14'd0, Cause}, 16'h0002);

        PCWrite = 1; isBranch = 1; Opcode = 4'd1; Zero = 1; PCSrc = 3'd1; ALUOut = 16'h0100;
        tick("pcw_and_br");
        check("pcwbr_pc", PC, 16'h0100);
        check("pcwbr_bt", {15'd0, BranchTaken}, 16'h0000);

        PCWrite = 1; PCSrc = 3'd1; ALUOut = 16'h0000;
        tick("load_zero");
        EPCWrite = 1;
        tick("exc_wrap");
        check("exc_wrap_epc", EPC, 16'hFFFE);

        // Reset between edges clears everything at once.
        Reset = 1'b1;
        #1;
        check("mid_rst_pc", PC, 16'h0000);
        check("mid_rst_epc", EPC, 16'h0000);
        check("mid_rst_cause", {14'd0, Cause}, 16'h0000);
        check("mid_rst_fc", FetchCount, 16'h0000);
        @(negedge CLK);
        Reset = 1'b0;

        ALUResult = 16'h0002;
        for (int i = 0; i < 65535; i++) begin
            PCWrite = 1; PCSrc = 3'd0;
            @(posedge CLK);
            #1;
        end
        idle();
        check("fc_ffff", FetchCount, 16'hFFFF);
        PCWrite = 1; PCSrc = 3'd0;
        tick("fc_wrap");
        check("fc_wrap", FetchCount, 16'h0000);

        // Reset during a pending taken branch; first edge after release acts on live inputs.
        isBranch = 1; Opcode = 4'd1; Zero = 1; PCSrc = 3'd1; ALUOut = 16'h0200;
        Reset = 1'b1;
        #1;
        check("rst_br_pc", PC, 16'h0000);
        check("rst_br_bt", {15'd0, BranchTaken}, 16'h0000);
        @(negedge CLK);
        Reset = 1'b0;
        idle();
        PCWrite = 1; PCSrc = 3'd0; ALUResult = 16'h0020;
        tick("post_rst");
        check("post_rst_pc", PC, 16'h0020);
        check("post_rst_fc", FetchCount, 16'h0001);
        check("post_rst_bt", {15'd0, BranchTaken}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
